// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a registered valid/ready response slot per requester.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [WIDTH-1:0]  req0_op1_i,
  input  logic [WIDTH-1:0]  req0_op2_i,
  input  logic [CTRL_W-1:0] req0_ctrl_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [WIDTH-1:0]  req1_op1_i,
  input  logic [WIDTH-1:0]  req1_op2_i,
  input  logic [CTRL_W-1:0] req1_ctrl_i,
  output logic [WIDTH-1:0]  alu_operand1_o,
  output logic [WIDTH-1:0]  alu_operand2_o,
  output logic [CTRL_W-1:0] alu_control_o,
  input  logic [WIDTH-1:0]  alu_result_i,
  input  logic              alu_zero_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [WIDTH-1:0]  rsp0_result_o,
  output logic              rsp0_zero_o,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [WIDTH-1:0]  rsp1_result_o,
  output logic              rsp1_zero_o
);

  logic             elig0_s, elig1_s;
  logic             grant0_s, grant1_s;
  logic             last_grant_r;
  logic             rsp0_valid_r, rsp1_valid_r;
  logic [WIDTH-1:0] rsp0_result_r, rsp1_result_r;
  logic             rsp0_zero_r, rsp1_zero_r;

  // Eligibility and round-robin grant; a slot draining this cycle may be refilled.
  always_comb begin
    elig0_s  = req0_valid_i & (~rsp0_valid_r | rsp0_ready_i);
    elig1_s  = req1_valid_i & (~rsp1_valid_r | rsp1_ready_i);
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst_i) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (elig0_s && elig1_s) begin
      grant0_s = last_grant_r;
      grant1_s = ~last_grant_r;
    end else begin
      grant0_s = elig0_s;
      grant1_s = elig1_s;
    end
  end

  // Steer the granted requester onto the ALU; idle drives all zeros.
  always_comb begin
    alu_operand1_o = {WIDTH{1'b0}};
    alu_operand2_o = {WIDTH{1'b0}};
    alu_control_o  = {CTRL_W{1'b0}};
    if (grant0_s) begin
      alu_operand1_o = req0_op1_i;
      alu_operand2_o = req0_op2_i;
      alu_control_o  = req0_ctrl_i;
    end else if (grant1_s) begin
      alu_operand1_o = req1_op1_i;
      alu_operand2_o = req1_op2_i;
      alu_control_o  = req1_ctrl_i;
    end else begin
      alu_operand1_o = {WIDTH{1'b0}};
      alu_operand2_o = {WIDTH{1'b0}};
      alu_control_o  = {CTRL_W{1'b0}};
    end
  end

  // Round-robin pointer remembers the most recent winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_r <= 1'b1;
    end else if (grant0_s) begin
      last_grant_r <= 1'b0;
    end else if (grant1_s) begin
      last_grant_r <= 1'b1;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Response slot 0: capture on grant, clear valid on drain, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp0_valid_r  <= 1'b0;
      rsp0_result_r <= {WIDTH{1'b0}};
      rsp0_zero_r   <= 1'b0;
    end else if (grant0_s) begin
      rsp0_valid_r  <= 1'b1;
      rsp0_result_r <= alu_result_i;
      rsp0_zero_r   <= alu_zero_i;
    end else if (rsp0_valid_r && rsp0_ready_i) begin
      rsp0_valid_r  <= 1'b0;
    end else begin
      rsp0_valid_r  <= rsp0_valid_r;
    end
  end

  // Response slot 1: same behaviour as slot 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp1_valid_r  <= 1'b0;
      rsp1_result_r <= {WIDTH{1'b0}};
      rsp1_zero_r   <= 1'b0;
    end else if (grant1_s) begin
      rsp1_valid_r  <= 1'b1;
      rsp1_result_r <= alu_result_i;
      rsp1_zero_r   <= alu_zero_i;
    end else if (rsp1_valid_r && rsp1_ready_i) begin
      rsp1_valid_r  <= 1'b0;
    end else begin
      rsp1_valid_r  <= rsp1_valid_r;
    end
  end

  assign req0_ready_o  = grant0_s;
  assign req1_ready_o  = grant1_s;
  assign rsp0_valid_o  = rsp0_valid_r;
  assign rsp0_result_o = rsp0_result_r;
  assign rsp0_zero_o   = rsp0_zero_r;
  assign rsp1_valid_o  = rsp1_valid_r;
  assign rsp1_result_o = rsp1_result_r;
  assign rsp1_zero_o   = rsp1_zero_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed requests push hand-computed
// results per requester; a negedge monitor pops them on each response handshake.
module tb_alu_share_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i;
  logic [3:0]  req0_ctrl_i, req1_ctrl_i;
  logic [31:0] alu_operand1_o, alu_operand2_o;
  logic [3:0]  alu_control_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        rsp0_valid_o, rsp0_ready_i, rsp0_zero_o;
  logic        rsp1_valid_o, rsp1_ready_i, rsp1_zero_o;
  logic [31:0] rsp0_result_o, rsp1_result_o;

  int errors = 0;
  int checks = 0;
  int pop0_cnt = 0;
  int pop1_cnt = 0;
  logic [32:0] sb0[$];
  logic [32:0] sb1[$];
  logic [31:0] exp0_res, exp1_res;
  logic        exp0_z, exp1_z;
  logic        g0, g1;
  logic [3:0]  ac;
  logic [31:0] a1;
  int          base0, base1;

  always #5 clk_i = ~clk_i;

  alu_share_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_op1_i(req0_op1_i), .req0_op2_i(req0_op2_i), .req0_ctrl_i(req0_ctrl_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_op1_i(req1_op1_i), .req1_op2_i(req1_op2_i), .req1_ctrl_i(req1_ctrl_i),
    .alu_operand1_o(alu_operand1_o), .alu_operand2_o(alu_operand2_o),
    .alu_control_o(alu_control_o), .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
    .rsp0_result_o(rsp0_result_o), .rsp0_zero_o(rsp0_zero_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
    .rsp1_result_o(rsp1_result_o), .rsp1_zero_o(rsp1_zero_o)
  );

  // External ALU the arbiter shares; unknown codes return 0.
  always_comb begin
    case (alu_control_o)
      4'b0000: alu_result_i = alu_operand1_o & alu_operand2_o;
      4'b0001: alu_result_i = alu_operand1_o | alu_operand2_o;
      4'b0010: alu_result_i = alu_operand1_o + alu_operand2_o;
      4'b0110: alu_result_i = alu_operand1_o - alu_operand2_o;
      4'b1100: alu_result_i = ~(alu_operand1_o | alu_operand2_o);
      default: alu_result_i = 32'd0;
    endcase
    alu_zero_i = (alu_result_i == 32'd0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: sample grants at negedge, log expected results for handshakes.
  task automatic tick();
    @(negedge clk_i);
    g0 = req0_ready_o;
    g1 = req1_ready_o;
    ac = alu_control_o;
    a1 = alu_operand1_o;
    if (g0 === 1'b1) sb0.push_back({exp0_z, exp0_res});
    if (g1 === 1'b1) sb1.push_back({exp1_z, exp1_res});
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: compare each response handshake against the scoreboard front.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0) begin
      if (rsp0_valid_o === 1'b1 && rsp0_ready_i === 1'b1) begin
        if (sb0.size() == 0) begin
          check("rsp0_unexpected", 64'd1, 64'd0);
        end else begin
          check("rsp0_data", {31'd0, rsp0_zero_o, rsp0_result_o}, {31'd0, sb0.pop_front()});
          pop0_cnt++;
        end
      end
      if (rsp1_valid_o === 1'b1 && rsp1_ready_i === 1'b1) begin
        if (sb1.size() == 0) begin
          check("rsp1_unexpected", 64'd1, 64'd0);
        end else begin
          check("rsp1_data", {31'd0, rsp1_zero_o, rsp1_result_o}, {31'd0, sb1.pop_front()});
          pop1_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    req0_valid_i = 1'b1; req0_op1_i = 32'd0; req0_op2_i = 32'd0; req0_ctrl_i = 4'd0;
    req1_valid_i = 1'b0; req1_op1_i = 32'd0; req1_op2_i = 32'd0; req1_ctrl_i = 4'd0;
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    exp0_res = 32'd0; exp0_z = 1'b0; exp1_res = 32'd0; exp1_z = 1'b0;
    @(posedge clk_i); #1;

    // Reset held two cycles; no grant even with a valid request
    tick(); check("reset_ready0", {63'd0, g0}, 64'd0);
    tick(); check("reset_ready0_b", {63'd0, g0}, 64'd0);
    check("reset_rsp0_valid", {63'd0, rsp0_valid_o}, 64'd0);
    check("reset_rsp1_valid", {63'd0, rsp1_valid_o}, 64'd0);
    check("reset_rsp0_result", {32'd0, rsp0_result_o}, 64'd0);
    check("reset_rsp1_zero", {63'd0, rsp1_zero_o}, 64'd0);

    // Basic add 5+7
    rst_i = 1'b0;
    req0_op1_i = 32'd5; req0_op2_i = 32'd7; req0_ctrl_i = 4'b0010;
    exp0_res = 32'd12; exp0_z = 1'b0;
    tick();
    check("add_ready0", {62'd0, g0, g1}, 64'd2);
    check("add_ctrl", {60'd0, ac}, 64'd2);
    req0_valid_i = 1'b0;
    check("add_latency", {63'd0, rsp0_valid_o}, 64'd1);
    check("add_result", {32'd0, rsp0_result_o}, 64'd12);
    tick();
    check("idle_ctrl", {60'd0, ac}, 64'd0);
    check("idle_op1", {32'd0, a1}, 64'd0);

    // Reset again so the pointer favours requester 0, then contention
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    req0_valid_i = 1'b1; req0_op1_i = 32'd9; req0_op2_i = 32'd9; req0_ctrl_i = 4'b0110;
    exp0_res = 32'd0; exp0_z = 1'b1;
    req1_valid_i = 1'b1; req1_op1_i = 32'hF0; req1_op2_i = 32'h0F; req1_ctrl_i = 4'b0001;
    exp1_res = 32'hFF; exp1_z = 1'b0;
    tick(); check("cont_first", {62'd0, g0, g1}, 64'd2);
    req0_valid_i = 1'b0;
    tick(); check("cont_second", {62'd0, g0, g1}, 64'd1);
    req1_valid_i = 1'b0;
    tick();

    // Sustained fairness: 6 cycles of contention alternate 0,1,0,1,0,1
    base0 = pop0_cnt; base1 = pop1_cnt;
    req0_valid_i = 1'b1; req0_op1_i = 32'd100; req0_op2_i = 32'd23; req0_ctrl_i = 4'b0010;
    exp0_res = 32'd123; exp0_z = 1'b0;
    req1_valid_i = 1'b1; req1_op1_i = 32'd50; req1_op2_i = 32'd8; req1_ctrl_i = 4'b0110;
    exp1_res = 32'd42; exp1_z = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("fair_grant%0d", k), {62'd0, g0, g1},
            ((k % 2) == 0) ? 64'd2 : 64'd1);
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    tick();
    check("fair_count0", 64'(pop0_cnt - base0), 64'd3);
    check("fair_count1", 64'(pop1_cnt - base1), 64'd3);

    // Backpressure on response 0
    rsp0_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_op1_i = 32'hFF; req0_op2_i = 32'h0F; req0_ctrl_i = 4'b0000;
    exp0_res = 32'h0F; exp0_z = 1'b0;
    tick(); check("bp_first", {62'd0, g0, g1}, 64'd2);
    req0_op1_i = 32'd1; req0_op2_i = 32'd2; req0_ctrl_i = 4'b0001;
    exp0_res = 32'd3; exp0_z = 1'b0;
    req1_valid_i = 1'b1; req1_op1_i = 32'd1; req1_op2_i = 32'd1; req1_ctrl_i = 4'b0010;
    exp1_res = 32'd2; exp1_z = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bp_grant%0d", k), {62'd0, g0, g1}, 64'd1);
      check($sformatf("bp_hold%0d", k), {31'd0, rsp0_valid_o, rsp0_result_o}, {31'd0, 1'b1, 32'h0F});
    end
    rsp0_ready_i = 1'b1;
    tick(); check("bp_release", {62'd0, g0, g1}, 64'd2);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    check("bp_update", {32'd0, rsp0_result_o}, 64'd3);
    tick();

    // Reset while response 1 is stalled
    rsp1_ready_i = 1'b0;
    req1_valid_i = 1'b1; req1_op1_i = 32'd6; req1_op2_i = 32'd7; req1_ctrl_i = 4'b0010;
    exp1_res = 32'd13; exp1_z = 1'b0;
    tick(); check("mid_grant", {62'd0, g0, g1}, 64'd1);
    req1_valid_i = 1'b0;
    tick(); check("mid_stalled", {63'd0, rsp1_valid_o}, 64'd1);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    sb0.delete(); sb1.delete();
    check("mid_rsp1_valid", {63'd0, rsp1_valid_o}, 64'd0);
    check("mid_rsp1_result", {31'd0, rsp1_zero_o, rsp1_result_o}, 64'd0);
    check("mid_rsp0_result", {31'd0, rsp0_zero_o, rsp0_result_o}, 64'd0);
    rsp1_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_op1_i = 32'd6; req0_op2_i = 32'd3; req0_ctrl_i = 4'b0000;
    exp0_res = 32'd2; exp0_z = 1'b0;
    req1_valid_i = 1'b1; req1_op1_i = 32'd1; req1_op2_i = 32'd2; req1_ctrl_i = 4'b0010;
    exp1_res = 32'd3; exp1_z = 1'b0;
    tick(); check("mid_first", {62'd0, g0, g1}, 64'd2);
    req0_valid_i = 1'b0;
    tick(); check("mid_second", {62'd0, g0, g1}, 64'd1);
    req1_valid_i = 1'b0;
    tick();

    // Undefined control code passes through; ALU returns 0 / zero
    req1_valid_i = 1'b1; req1_op1_i = 32'd3; req1_op2_i = 32'd4; req1_ctrl_i = 4'b1010;
    exp1_res = 32'd0; exp1_z = 1'b1;
    tick();
    check("undef_grant", {62'd0, g0, g1}, 64'd1);
    check("undef_ctrl", {60'd0, ac}, 64'hA);
    req1_valid_i = 1'b0;
    check("undef_rsp", {30'd0, rsp1_valid_o, rsp1_zero_o, rsp1_result_o}, {30'd0, 1'b1, 1'b1, 32'd0});
    tick();
    tick();

    check("sb0_empty", 64'(sb0.size()), 64'd0);
    check("sb1_empty", 64'(sb1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, for example the integer pipe and the address/branch-compare path.
- Each cycle it selects at most one requester using round-robin and drives that requester's operands and ALU control onto the ALU.
- It captures the result and zero flag into a per-requester response register.
- Both the request side and the response side use valid/ready handshakes.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CTRL_W, 4, ALU control code width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req0_valid_i  in  1  requester 0 has an operation.
- req0_ready_o  out  1  requester 0 granted this cycle (handshake fires).
- req0_op1_i  in  WIDTH  requester 0 operand 1.
- req0_op2_i  in  WIDTH  requester 0 operand 2.
- req0_ctrl_i  in  CTRL_W  requester 0 ALU control code.
- req1_valid_i, req1_ready_o, req1_op1_i, req1_op2_i, req1_ctrl_i  same as requester 0, for requester 1.
- alu_operand1_o  out  WIDTH  to ALU operand 1.
- alu_operand2_o  out  WIDTH  to ALU operand 2.
- alu_control_o  out  CTRL_W  to ALU control.
- alu_result_i  in  WIDTH  from ALU result.
- alu_zero_i  in  1  from ALU zero flag.
- rsp0_valid_o  out  1  response 0 holds a result.
- rsp0_ready_i  in  1  consumer 0 accepts the response.
- rsp0_result_o  out  WIDTH  captured result.
- rsp0_zero_o  out  1  captured zero flag.
- rsp1_valid_o, rsp1_ready_i, rsp1_result_o, rsp1_zero_o  same as response 0, for requester 1.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - rsp0/1_valid_o=0, rsp0/1_result_o=0, rsp0/1_zero_o=0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first contention.
  - While rst_i=1, req0/1_ready_o=0 and no grant is issued.
- Eligibility, per requester i: eligible_i = reqi_valid_i & (~rspi_valid_o | rspi_ready_i). A full response slot being drained in the same cycle can be refilled in that cycle.
- Arbitration (combinational, one grant per cycle):
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester != last_grant.
  - Neither eligible: no grant.
- reqi_ready_o = grant_i. It is combinational and depends on reqi_valid_i and rspi_ready_i.
- ALU drive:
  - On a grant: alu_operand1_o, alu_operand2_o and alu_control_o = granted requester's op1, op2 and ctrl.
  - No grant: operands=0, control=4'b0000.
- Capture, at the rising edge with grant_i=1:
  - rspi_result_o <= alu_result_i, rspi_zero_o <= alu_zero_i, rspi_valid_o <= 1.
  - last_grant <= i.
- Latency: a request handshake in cycle N gives rspi_valid_o=1 from cycle N+1.
- Drain: if rspi_valid_o & rspi_ready_i and there is no new grant_i, then rspi_valid_o <= 0. Result and zero hold their last value.
- Stability rules:
  - Requester must hold valid, op1, op2 and ctrl stable while valid & ~ready.
  - Block holds rsp* stable while rspi_valid_o & ~rspi_ready_i.
- Throughput: one ALU operation per cycle in total. Sustained contention alternates 0,1,0,1…
- Control codes are passed through unmodified. Undefined codes yield whatever the ALU returns (result 0, zero 1); no error flag.
- Simultaneous drain and grant for the same requester: the new result overwrites and valid stays 1.
- Reset mid-operation: pending responses are discarded with no handshake, and the pointer returns to 1.

Test Plan:
- Basic add:
  - Stimulus: rst_i held 2 cycles, then req0 ADD op1=5, op2=7, ctrl=0010, rsp0_ready_i=1.
  - Response: req0_ready_o=1 in the same cycle; alu_control_o=0010; next cycle rsp0_valid_o=1, result=12, zero=0.
- Contention after reset:
  - Stimulus: both valid; req0 SUB 9-9 (0110); req1 OR 0xF0|0x0F (0001).
  - Response: cycle 0 grants 0 and cycle 1 grants 1; rsp0 result=0, zero=1; rsp1 result=0xFF, zero=0.
- Sustained fairness:
  - Stimulus: both requesters valid for 6 cycles, both rsp ready=1.
  - Response: grants exactly 0,1,0,1,0,1; 6 responses, 3 per side.
- Backpressure:
  - Stimulus: rsp0_valid_o=1, rsp0_ready_i=0, req0 and req1 valid.
  - Response: req0_ready_o=0 and req1 is granted every cycle; rsp0 is unchanged.
  - Then raise rsp0_ready_i: req0 is granted in that cycle (pointer permitting) and rsp0 is updated the next cycle.
- Reset mid-operation:
  - Stimulus: rsp1_valid_o=1 stalled, assert rst_i 1 cycle.
  - Response: rsp1_valid_o=0 and results=0; the next contention grants req0 first.
- Undefined code:
  - Stimulus: req1 ctrl=1010, op1=3, op2=4.
  - Response: rsp1 result=0, zero=1 one cycle later.
